// File: rtl/xalu_nibble_sequencer_if.sv
// xalu_nibble_sequencer_if: nibble-wide bus between the sequencer and one 4-bit xalu slice.
interface xalu_nibble_sequencer_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    logic       com;
    logic       ci_right;
    logic       ci_left;
    logic [3:0] d;
    logic       co_left;
    logic       co_right;
    logic       equ;
    modport master (output a, b, f, com, ci_right, ci_left, input d, co_left, co_right, equ);
    modport slave  (input a, b, f, com, ci_right, ci_left, output d, co_left, co_right, equ);
endinterface

// File: rtl/xalu_nibble_sequencer.sv
// xalu_nibble_sequencer: runs a WIDTH-bit operation nibble-serially through one xalu slice.
module xalu_nibble_sequencer #(
    parameter int NIBBLES = 4,
    localparam int WIDTH = 4 * NIBBLES,
    localparam int IW = $clog2(NIBBLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           func,
    input  logic                 com,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     a_word,
    input  logic [WIDTH-1:0]     b_word,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 carry_out,
    output logic                 zero,
    output logic                 equ,
    xalu_nibble_sequencer_if.master alu
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_next;
    logic [2:0]        f_q;
    logic              com_q, carry, carry_next, equ_acc, run, shr, last;
    logic [IW-1:0]     idx, sel;
    always_comb begin
        run        = state_q == S_RUN;
        shr        = f_q == 3'd6;
        last       = idx == IW'(NIBBLES - 1);
        sel        = shr ? IW'(NIBBLES - 1) - idx : idx;
        state_d    = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = last ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
        endcase
        busy         = run;
        done         = state_q == S_DONE;
        alu.a        = run ? a_q[sel*4 +: 4] : 4'd0;
        alu.b        = run ? b_q[sel*4 +: 4] : 4'd0;
        alu.f        = run ? f_q : 3'd0;
        alu.com      = run & com_q;
        alu.ci_right = run & ~shr & carry;
        alu.ci_left  = run & shr & carry;
        // SHR ripples toward the LS end, so its chain exits on the right.
        carry_next   = shr ? alu.co_right : alu.co_left;
        res_next     = result;
        res_next[sel*4 +: 4] = alu.d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            com_q     <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            equ_acc   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            equ       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                a_q       <= a_word;
                b_q       <= b_word;
                f_q       <= func;
                com_q     <= com;
                idx       <= '0;
                carry     <= cin;
                equ_acc   <= 1'b1;
                result    <= '0;
                carry_out <= 1'b0;
                zero      <= 1'b0;
                equ       <= 1'b0;
            end else if (run) begin
                result  <= res_next;
                carry   <= carry_next;
                equ_acc <= equ_acc & alu.equ;
                idx     <= idx + 1'b1;
                if (last) begin
                    carry_out <= carry_next;
                    zero      <= res_next == '0;
                    equ       <= equ_acc & alu.equ;
                end
            end
        end
    end
endmodule

// File: tb/tb_xalu_nibble_sequencer.sv
// tb_xalu_nibble_sequencer: directed checks of the sequencer driving a behavioural xalu slice.
module tb_xalu_nibble_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func = 3'd0;
    logic        com = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a_word = '0;
    logic [15:0] b_word = '0;
    logic        busy, done, carry_out, zero, equ;
    logic [15:0] result;
    int          checks = 0;
    int          fails = 0;
    xalu_nibble_sequencer_if bus();
    xalu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .com(com), .cin(cin),
        .a_word(a_word), .b_word(b_word), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero(zero), .equ(equ), .alu(bus.master)
    );
    always #5 clk = ~clk;
    // 4-bit xalu slice model
    logic [4:0] sum;
    logic [3:0] y;
    logic       cl, cr;
    always_comb begin
        sum = {1'b0, bus.a} + {1'b0, bus.b} + {4'd0, bus.ci_right};
        y   = 4'd0;
        cl  = 1'b0;
        cr  = 1'b0;
        case (bus.f)
            3'd0: begin y = sum[3:0]; cl = sum[4]; end
            3'd1: y = bus.a & bus.b;
            3'd2: y = bus.a | bus.b;
            3'd3: y = bus.a ^ bus.b;
            3'd4: y = bus.a;
            3'd5: y = bus.b;
            3'd6: begin y = {bus.ci_left, bus.a[3:1]}; cr = bus.a[0]; end
            default: begin y = {bus.a[2:0], bus.ci_right}; cl = bus.a[3]; end
        endcase
        bus.d        = bus.com ? ~y : y;
        bus.co_left  = cl;
        bus.co_right = cr;
        bus.equ      = bus.a == bus.b;
    end
    task automatic run_op(input [2:0] f, input c, input ci, input [15:0] a, input [15:0] b, output int lat);
        @(negedge clk);
        func = f; com = c; cin = ci; a_word = a; b_word = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic check_op(input string name, input int lat, input [15:0] r, input co, input z, input e);
        checks++;
        if (lat !== 4) begin fails++; $display("FAIL %s latency got %0d want 4", name, lat); end
        checks++;
        if (result !== r) begin fails++; $display("FAIL %s result got %h want %h", name, result, r); end
        checks++;
        if ({carry_out, zero, equ} !== {co, z, e})
            begin fails++; $display("FAIL %s flags co/z/e got %b want %b", name, {carry_out, zero, equ}, {co, z, e}); end
    endtask
    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, carry_out, zero, equ} !== 5'b0 || result !== 16'h0)
            begin fails++; $display("FAIL reset outputs got %b/%h want 0", {busy, done, carry_out, zero, equ}, result); end
        checks++;
        if ({bus.a, bus.b, bus.f, bus.com, bus.ci_right, bus.ci_left} !== 15'd0)
            begin fails++; $display("FAIL reset alu bus got %h want 0", {bus.a, bus.b, bus.f, bus.com, bus.ci_right, bus.ci_left}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_add;
        int lat;
        run_op(3'd0, 1'b0, 1'b0, 16'h00FF, 16'h0001, lat);
        check_op("add_00ff", lat, 16'h0100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'h0100)
            begin fails++; $display("FAIL add_hold done/result got %b/%h want 0/0100", done, result); end
        checks++;
        if ({bus.a, bus.f, bus.ci_right} !== 8'd0)
            begin fails++; $display("FAIL idle_bus got %h want 0", {bus.a, bus.f, bus.ci_right}); end
        run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, lat);
        check_op("add_wrap", lat, 16'h0000, 1'b1, 1'b1, 1'b0);
    endtask
    task automatic test_shift;
        int lat;
        run_op(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, lat);
        check_op("shr", lat, 16'hC000, 1'b1, 1'b0, 1'b0);
        run_op(3'd7, 1'b0, 1'b0, 16'h8001, 16'h0000, lat);
        check_op("shl", lat, 16'h0002, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic test_logic;
        int lat;
        run_op(3'd1, 1'b0, 1'b0, 16'h1234, 16'h1234, lat);
        check_op("and_eq", lat, 16'h1234, 1'b0, 1'b0, 1'b1);
        run_op(3'd3, 1'b0, 1'b0, 16'h1234, 16'h1235, lat);
        check_op("xor_ne", lat, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(3'd4, 1'b1, 1'b0, 16'h0F0F, 16'h0000, lat);
        check_op("passa_com", lat, 16'hF0F0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_back_to_back;
        int dones = 0;
        @(negedge clk);
        func = 3'd0; com = 1'b0; cin = 1'b0; a_word = 16'h0001; b_word = 16'h0002; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) a_word = 16'hFFFF;
            if (i == 5) start = 1'b0;
            if (done) dones++;
        end
        checks++;
        if (dones !== 1) begin fails++; $display("FAIL b2b done_count got %0d want 1", dones); end
        checks++;
        if (result !== 16'h0003) begin fails++; $display("FAIL b2b result got %h want 0003", result); end
    endtask
    task automatic test_reset_mid_run;
        int dones = 0;
        @(negedge clk);
        func = 3'd0; a_word = 16'h1111; b_word = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result[7:0] !== 8'h22)
            begin fails++; $display("FAIL midrun_partial busy/result got %b/%h want 1/xx22", busy, result); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || result !== 16'h0)
            begin fails++; $display("FAIL midrun_abort busy/done/result got %b/%h want 00/0000", {busy, done}, result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin fails++; $display("FAIL midrun_no_done got %0d want 0", dones); end
    endtask
    initial begin
        test_reset;
        test_add;
        test_shift;
        test_logic;
        test_back_to_back;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
